// File: rtl/axi_lite_mem_responder_pkg.sv
// Shared definitions for the AXI4-Lite memory responder: response codes,
// arbitration priority values, FSM state encodings and the held write request.
package axi_lite_mem_responder_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Round-robin priority flag values
    localparam logic PRIO_READ  = 1'b0;
    localparam logic PRIO_WRITE = 1'b1;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WCOL  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_RRESP = 3'd3;
    localparam logic [2:0] ST_BRESP = 3'd4;

    // Write request collected from the AW and W channels
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_req_t;

endpackage

// File: rtl/axi_lite_mem_responder_sram_core.sv
// Single-port word RAM with four byte-lane write enables and a registered
// read port. Contents are never reset; only the read register is cleared so
// the responder's read data bus starts at zero.
module axi_lite_sram_core #(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] idx,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0] mem [DEPTH];

    // Byte-lane write: each strobe bit updates its own 8-bit lane
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (wr_be[n]) begin
                    mem[idx][8*n +: 8] <= wr_data[8*n +: 8];
                end
            end
        end
    end

    // Synchronous read register, held between reads so data stays stable
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/axi_lite_mem_responder.sv
// AXI4-Lite-style memory responder. One transaction is in service at a time:
// reads go IDLE -> RRESP, writes go IDLE -> (WCOL) -> WRITE -> BRESP. When a
// read and a write compete in IDLE a round-robin flag decides who goes first.
// Optional feature macro: AXI_RESP_ERR_EN adds Rresp/Bresp and reports SLVERR
// for out-of-window addresses and misaligned full-word writes.
module axi_lite_mem_responder
    import axi_lite_mem_responder_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter string       INIT_FILE = ""
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        ARvalid,
    output logic        ARready,
    input  logic [31:0] ARdata,
    input  logic [2:0]  arprot,
    output logic        Rvalid,
    input  logic        RReady,
    output logic [31:0] Rdata,
    input  logic        AWvalid,
    output logic        AWready,
    input  logic [31:0] AWdata,
    input  logic [2:0]  awprot,
    input  logic        Wvalid,
    output logic        Wready,
    input  logic [31:0] Wdata,
    input  logic [3:0]  Wstrb,
    output logic        Bvalid,
`ifdef AXI_RESP_ERR_EN
    output logic [1:0]  Rresp,
    output logic [1:0]  Bresp,
`endif
    input  logic        Bready
);

    logic [2:0]        state;
    logic              prio;
    logic              aw_held;
    logic              w_held;
    wr_req_t           req;
    logic              rvalid_q;
    logic              bvalid_q;

    logic              wr_pending;
    logic              read_grant;
    logic              write_grant;
    logic              aw_hs;
    logic              w_hs;
    logic [31:0]       ar_offset;
    logic [31:0]       wr_offset;
    logic [ADDR_W-1:0] ram_idx;
    logic              ram_rd_en;
    logic              ram_wr_en;
    logic [31:0]       ram_rdata;
    logic              rd_err;
    logic              wr_err;
    logic              unused_inputs;

    // Arbitration in IDLE: a read wins unless a write is also asking and it is the write's turn
    always_comb begin
        wr_pending  = AWvalid || Wvalid;
        read_grant  = (state == ST_IDLE) && ARvalid && (!wr_pending || prio == PRIO_READ);
        write_grant = (state == ST_IDLE) && !read_grant && wr_pending;
    end

    // Ready generation: AW and W can be taken together or one at a time while collecting
    always_comb begin
        ARready = read_grant;
        AWready = 1'b0;
        Wready  = 1'b0;
        if (write_grant) begin
            AWready = AWvalid;
            Wready  = Wvalid;
        end else if (state == ST_WCOL) begin
            AWready = !aw_held;
            Wready  = !w_held;
        end
        aw_hs = AWvalid && AWready;
        w_hs  = Wvalid && Wready;
    end

    // Address-to-index mapping; the RAM port is shared between the read grant and the write commit
    always_comb begin
        ar_offset = ARdata - BASE_ADDR;
        wr_offset = req.addr - BASE_ADDR;
        ram_idx   = (state == ST_WRITE) ? wr_offset[ADDR_W+1:2] : ar_offset[ADDR_W+1:2];
        ram_rd_en = read_grant;
        ram_wr_en = (state == ST_WRITE) && !wr_err;
    end

`ifdef AXI_RESP_ERR_EN
    localparam logic [32:0] WINDOW_BYTES = 33'(1) << (ADDR_W + 2);

    logic rd_err_q;
    logic bresp_err_q;

    // Error detection: outside the RAM window, or a full-word write to a misaligned address
    always_comb begin
        rd_err = ({1'b0, ar_offset} >= WINDOW_BYTES);
        wr_err = ({1'b0, wr_offset} >= WINDOW_BYTES)
              || ((req.addr[1:0] != 2'b00) && (req.strb == 4'hF));
    end

    // Response code registers, captured when the read is granted or the write commits
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_err_q    <= 1'b0;
            bresp_err_q <= 1'b0;
        end else begin
            if (read_grant) begin
                rd_err_q <= rd_err;
            end
            if (state == ST_WRITE) begin
                bresp_err_q <= wr_err;
            end
        end
    end

    assign Rdata = rd_err_q ? 32'h0 : ram_rdata;
    assign Rresp = rd_err_q ? RESP_SLVERR : RESP_OKAY;
    assign Bresp = bresp_err_q ? RESP_SLVERR : RESP_OKAY;
`else
    // Without error reporting every address wraps into the RAM and always succeeds
    always_comb begin
        rd_err = 1'b0;
        wr_err = 1'b0;
    end

    assign Rdata = ram_rdata;
`endif

    assign Rvalid = rvalid_q;
    assign Bvalid = bvalid_q;

    assign unused_inputs = ^{arprot, awprot, ar_offset, wr_offset, rd_err};

    // Main FSM: grants, holding registers, response valids and round-robin priority
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            prio     <= PRIO_READ;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            req      <= '0;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (read_grant) begin
                        rvalid_q <= 1'b1;
                        state    <= ST_RRESP;
                    end else if (write_grant) begin
                        if (aw_hs) begin
                            req.addr <= AWdata;
                            aw_held  <= 1'b1;
                        end
                        if (w_hs) begin
                            req.data <= Wdata;
                            req.strb <= Wstrb;
                            w_held   <= 1'b1;
                        end
                        state <= (aw_hs && w_hs) ? ST_WRITE : ST_WCOL;
                    end
                end
                ST_WCOL: begin
                    if (aw_hs) begin
                        req.addr <= AWdata;
                        aw_held  <= 1'b1;
                    end
                    if (w_hs) begin
                        req.data <= Wdata;
                        req.strb <= Wstrb;
                        w_held   <= 1'b1;
                    end
                    if ((aw_held || aw_hs) && (w_held || w_hs)) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    bvalid_q <= 1'b1;
                    state    <= ST_BRESP;
                end
                ST_RRESP: begin
                    if (RReady) begin
                        rvalid_q <= 1'b0;
                        prio     <= PRIO_WRITE;
                        state    <= ST_IDLE;
                    end
                end
                ST_BRESP: begin
                    if (Bready) begin
                        bvalid_q <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        prio     <= PRIO_READ;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    axi_lite_sram_core #(
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_sram (
        .clock   (clock),
        .resetn  (resetn),
        .idx     (ram_idx),
        .rd_en   (ram_rd_en),
        .wr_en   (ram_wr_en),
        .wr_be   (req.strb),
        .wr_data (req.data),
        .rd_data (ram_rdata)
    );

endmodule

// File: tb/tb_axi_lite_mem_responder.sv
// Directed self-checking bench for axi_lite_mem_responder: single writes and
// reads, split AW/W, backpressure, round-robin arbitration, mid-transaction
// reset and out-of-window addressing (with or without AXI_RESP_ERR_EN).
module tb_axi_lite_mem_responder;

    logic        clock;
    logic        resetn;
    logic        ARvalid;
    logic        ARready;
    logic [31:0] ARdata;
    logic [2:0]  arprot;
    logic        Rvalid;
    logic        RReady;
    logic [31:0] Rdata;
    logic        AWvalid;
    logic        AWready;
    logic [31:0] AWdata;
    logic [2:0]  awprot;
    logic        Wvalid;
    logic        Wready;
    logic [31:0] Wdata;
    logic [3:0]  Wstrb;
    logic        Bvalid;
    logic        Bready;
`ifdef AXI_RESP_ERR_EN
    logic [1:0]  Rresp;
    logic [1:0]  Bresp;
`endif

    int compared;
    int mismatched;

    axi_lite_mem_responder #(
        .ADDR_W    (10),
        .BASE_ADDR (32'h0000_0000),
        .INIT_FILE ("")
    ) dut (
        .clock   (clock),
        .resetn  (resetn),
        .ARvalid (ARvalid),
        .ARready (ARready),
        .ARdata  (ARdata),
        .arprot  (arprot),
        .Rvalid  (Rvalid),
        .RReady  (RReady),
        .Rdata   (Rdata),
        .AWvalid (AWvalid),
        .AWready (AWready),
        .AWdata  (AWdata),
        .awprot  (awprot),
        .Wvalid  (Wvalid),
        .Wready  (Wready),
        .Wdata   (Wdata),
        .Wstrb   (Wstrb),
        .Bvalid  (Bvalid),
`ifdef AXI_RESP_ERR_EN
        .Rresp   (Rresp),
        .Bresp   (Bresp),
`endif
        .Bready  (Bready)
    );

    // Free-running clock, 10 time units per period
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Idle all master-driven inputs
    task automatic clear_inputs();
        ARvalid = 1'b0; ARdata = '0; arprot = '0; RReady = 1'b0;
        AWvalid = 1'b0; AWdata = '0; awprot = '0;
        Wvalid = 1'b0; Wdata = '0; Wstrb = '0; Bready = 1'b0;
    endtask

    // Reset pulse with idle inputs
    task automatic apply_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Write with AW and W together; lat = cycles from handshake cycle to Bvalid (-1 if never ready)
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output int lat, output logic [1:0] resp);
        int n;
        AWvalid = 1'b1; AWdata = addr; Wvalid = 1'b1; Wdata = data; Wstrb = strb;
        #1;
        n = 0;
        while (!(AWready && Wready) && n < 10) begin
            tick();
            n++;
        end
        lat  = -1;
        resp = 2'b11;
        if (AWready && Wready) begin
            tick();
            AWvalid = 1'b0; Wvalid = 1'b0;
            lat = 1;
            while (!Bvalid && lat < 20) begin
                tick();
                lat++;
            end
`ifdef AXI_RESP_ERR_EN
            resp = Bresp;
`else
            resp = 2'b00;
`endif
            Bready = 1'b1;
            tick();
            Bready = 1'b0;
        end else begin
            AWvalid = 1'b0; Wvalid = 1'b0;
        end
    endtask

    // Read; lat = cycles from AR handshake cycle to Rvalid (-1 if never ready)
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output int lat,
                           output logic [1:0] resp);
        int n;
        ARvalid = 1'b1; ARdata = addr;
        #1;
        n = 0;
        while (!ARready && n < 10) begin
            tick();
            n++;
        end
        lat  = -1;
        data = 32'hxxxx_xxxx;
        resp = 2'b11;
        if (ARready) begin
            tick();
            ARvalid = 1'b0;
            lat = 1;
            while (!Rvalid && lat < 20) begin
                tick();
                lat++;
            end
            data = Rdata;
`ifdef AXI_RESP_ERR_EN
            resp = Rresp;
`else
            resp = 2'b00;
`endif
            RReady = 1'b1;
            tick();
            RReady = 1'b0;
        end else begin
            ARvalid = 1'b0;
        end
    endtask

    // Outputs while reset is held
    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        #2;
        compared++;
        if (Rvalid !== 1'b0) begin mismatched++; $display("FAIL reset_rvalid: got %b expected 0", Rvalid); end
        compared++;
        if (Bvalid !== 1'b0) begin mismatched++; $display("FAIL reset_bvalid: got %b expected 0", Bvalid); end
        compared++;
        if (Rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rdata: got %h expected 00000000", Rdata); end
        compared++;
        if (ARready !== 1'b0) begin mismatched++; $display("FAIL reset_arready: got %b expected 0", ARready); end
        tick();
        resetn = 1'b1;
        tick();
    endtask

    // Full-word write then readback, with latency checks
    task automatic test_single_write_read();
        int lat;
        logic [1:0] resp;
        logic [31:0] data;
        do_write(32'h10, 32'hDEADBEEF, 4'hF, lat, resp);
        compared++;
        if (lat !== 2) begin mismatched++; $display("FAIL wr1_latency: got %0d expected 2", lat); end
        do_read(32'h10, data, lat, resp);
        compared++;
        if (lat !== 1) begin mismatched++; $display("FAIL rd1_latency: got %0d expected 1", lat); end
        compared++;
        if (data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rd1_data: got %h expected deadbeef", data); end
    endtask

    // W arrives alone, AW three cycles later; byte-lane merge
    task automatic test_split_write();
        int lat;
        logic [1:0] resp;
        logic [31:0] data;
        Wvalid = 1'b1; Wdata = 32'h0000_00AA; Wstrb = 4'b0001;
        #1;
        compared++;
        if (Wready !== 1'b1) begin mismatched++; $display("FAIL split_wready: got %b expected 1", Wready); end
        tick();
        Wvalid = 1'b0;
        compared++;
        if (Wready !== 1'b0) begin mismatched++; $display("FAIL split_wready_held: got %b expected 0", Wready); end
        tick();
        tick();
        AWvalid = 1'b1; AWdata = 32'h10;
        #1;
        compared++;
        if (AWready !== 1'b1) begin mismatched++; $display("FAIL split_awready: got %b expected 1", AWready); end
        tick();
        AWvalid = 1'b0;
        lat = 1;
        while (!Bvalid && lat < 20) begin
            tick();
            lat++;
        end
        compared++;
        if (lat !== 2) begin mismatched++; $display("FAIL split_b_latency: got %0d expected 2", lat); end
        Bready = 1'b1;
        tick();
        Bready = 1'b0;
        do_read(32'h10, data, lat, resp);
        compared++;
        if (data !== 32'hDEADBEAA) begin mismatched++; $display("FAIL split_rd_data: got %h expected deadbeaa", data); end
    endtask

    // Rvalid/Bvalid held under backpressure, no new requests accepted
    task automatic test_backpressure();
        ARvalid = 1'b1; ARdata = 32'h10;
        #1;
        tick();
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (Rvalid !== 1'b1 || Rdata !== 32'hDEADBEAA || ARready !== 1'b0) begin
                mismatched++;
                $display("FAIL r_stall[%0d]: got rvalid=%b rdata=%h arready=%b expected 1 deadbeaa 0",
                         i, Rvalid, Rdata, ARready);
            end
            tick();
        end
        ARvalid = 1'b0; RReady = 1'b1;
        tick();
        RReady = 1'b0;
        compared++;
        if (Rvalid !== 1'b0) begin mismatched++; $display("FAIL r_release: got %b expected 0", Rvalid); end

        AWvalid = 1'b1; AWdata = 32'h20; Wvalid = 1'b1; Wdata = 32'h1234_5678; Wstrb = 4'hF;
        #1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (Bvalid !== 1'b1 || AWready !== 1'b0 || Wready !== 1'b0) begin
                mismatched++;
                $display("FAIL b_stall[%0d]: got bvalid=%b awready=%b wready=%b expected 1 0 0",
                         i, Bvalid, AWready, Wready);
            end
            tick();
        end
        AWvalid = 1'b0; Wvalid = 1'b0; Bready = 1'b1;
        tick();
        Bready = 1'b0;
        compared++;
        if (Bvalid !== 1'b0) begin mismatched++; $display("FAIL b_release: got %b expected 0", Bvalid); end
    endtask

    // Round-robin between simultaneous read and write requests
    task automatic test_arbitration();
        int lat;
        logic [1:0] resp;
        logic [31:0] data;
        apply_reset();
        ARvalid = 1'b1; ARdata = 32'h20;
        AWvalid = 1'b1; AWdata = 32'h30; Wvalid = 1'b1; Wdata = 32'hCAFE_F00D; Wstrb = 4'hF;
        #1;
        compared++;
        if (ARready !== 1'b1 || AWready !== 1'b0) begin
            mismatched++;
            $display("FAIL arb1_grant: got arready=%b awready=%b expected 1 0", ARready, AWready);
        end
        tick();
        ARvalid = 1'b0;
        compared++;
        if (Rvalid !== 1'b1 || Rdata !== 32'h1234_5678) begin
            mismatched++;
            $display("FAIL arb1_rdata: got rvalid=%b rdata=%h expected 1 12345678", Rvalid, Rdata);
        end
        RReady = 1'b1;
        tick();
        RReady = 1'b0;
        compared++;
        if (AWready !== 1'b1 || Wready !== 1'b1) begin
            mismatched++;
            $display("FAIL arb1_write_next: got awready=%b wready=%b expected 1 1", AWready, Wready);
        end
        tick();
        AWvalid = 1'b0; Wvalid = 1'b0;
        tick();
        compared++;
        if (Bvalid !== 1'b1) begin mismatched++; $display("FAIL arb1_bvalid: got %b expected 1", Bvalid); end
        Bready = 1'b1;
        tick();
        Bready = 1'b0;

        do_read(32'h30, data, lat, resp);
        compared++;
        if (data !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL arb1_wr_data: got %h expected cafef00d", data); end

        ARvalid = 1'b1; ARdata = 32'h30;
        AWvalid = 1'b1; AWdata = 32'h40; Wvalid = 1'b1; Wdata = 32'h0BAD_CAFE; Wstrb = 4'hF;
        #1;
        compared++;
        if (ARready !== 1'b0 || AWready !== 1'b1) begin
            mismatched++;
            $display("FAIL arb2_grant: got arready=%b awready=%b expected 0 1", ARready, AWready);
        end
        tick();
        AWvalid = 1'b0; Wvalid = 1'b0;
        tick();
        compared++;
        if (Bvalid !== 1'b1) begin mismatched++; $display("FAIL arb2_bvalid: got %b expected 1", Bvalid); end
        Bready = 1'b1;
        tick();
        Bready = 1'b0;
        compared++;
        if (ARready !== 1'b1) begin mismatched++; $display("FAIL arb2_read_next: got %b expected 1", ARready); end
        tick();
        ARvalid = 1'b0;
        compared++;
        if (Rvalid !== 1'b1 || Rdata !== 32'hCAFE_F00D) begin
            mismatched++;
            $display("FAIL arb2_rdata: got rvalid=%b rdata=%h expected 1 cafef00d", Rvalid, Rdata);
        end
        RReady = 1'b1;
        tick();
        RReady = 1'b0;
        do_read(32'h40, data, lat, resp);
        compared++;
        if (data !== 32'h0BAD_CAFE) begin mismatched++; $display("FAIL arb2_wr_data: got %h expected 0badcafe", data); end
    endtask

    // Reset while collecting a write with only the address held
    task automatic test_reset_mid_write();
        int lat;
        logic [1:0] resp;
        logic [31:0] data;
        AWvalid = 1'b1; AWdata = 32'h10;
        #1;
        tick();
        AWvalid = 1'b0;
        #1;
        compared++;
        if (Wready !== 1'b1) begin mismatched++; $display("FAIL wcol_wready: got %b expected 1", Wready); end
        resetn = 1'b0;
        #1;
        compared++;
        if (Wready !== 1'b0 || Rvalid !== 1'b0 || Bvalid !== 1'b0 || Rdata !== 32'h0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got wready=%b rvalid=%b bvalid=%b rdata=%h expected 0 0 0 00000000",
                     Wready, Rvalid, Bvalid, Rdata);
        end
        tick();
        resetn = 1'b1;
        tick();
        do_read(32'h10, data, lat, resp);
        compared++;
        if (data !== 32'hDEADBEAA) begin mismatched++; $display("FAIL midreset_ram: got %h expected deadbeaa", data); end
        do_write(32'h10, 32'h5566_7788, 4'hF, lat, resp);
        compared++;
        if (lat !== 2) begin mismatched++; $display("FAIL midreset_wr_latency: got %0d expected 2", lat); end
        do_read(32'h10, data, lat, resp);
        compared++;
        if (data !== 32'h5566_7788) begin mismatched++; $display("FAIL midreset_wr_data: got %h expected 55667788", data); end
    endtask

    // Address one window past the RAM: wraps to word 0, or SLVERR when error reporting is built in
    task automatic test_out_of_range();
        int lat;
        logic [1:0] resp;
        logic [31:0] data;
        do_write(32'h0, 32'h1111_1111, 4'hF, lat, resp);
        do_write(32'h1000, 32'hA5A5_A5A5, 4'hF, lat, resp);
`ifdef AXI_RESP_ERR_EN
        compared++;
        if (resp !== 2'b10) begin mismatched++; $display("FAIL oor_bresp: got %b expected 10", resp); end
        do_read(32'h0, data, lat, resp);
        compared++;
        if (data !== 32'h1111_1111) begin mismatched++; $display("FAIL oor_word0: got %h expected 11111111", data); end
        compared++;
        if (resp !== 2'b00) begin mismatched++; $display("FAIL oor_word0_rresp: got %b expected 00", resp); end
        do_read(32'h1000, data, lat, resp);
        compared++;
        if (data !== 32'h0 || resp !== 2'b10) begin
            mismatched++;
            $display("FAIL oor_read: got rdata=%h rresp=%b expected 00000000 10", data, resp);
        end
`else
        compared++;
        if (lat !== 2) begin mismatched++; $display("FAIL oor_wr_latency: got %0d expected 2", lat); end
        do_read(32'h0, data, lat, resp);
        compared++;
        if (data !== 32'hA5A5_A5A5) begin mismatched++; $display("FAIL oor_wrap: got %h expected a5a5a5a5", data); end
`endif
    endtask

    // Test sequence
    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_single_write_read();
        test_split_write();
        test_backpressure();
        test_arbitration();
        test_reset_mid_write();
        test_out_of_range();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
